// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the pipeline hazard controller: the controller state
// encoding, the default data-memory timeout and the wait counter width.
// No ports (package).
// -----------------------------------------------------------------------------
package pipeline_pkg;

    // Controller states. The encoding is fixed so other tools that decode
    // the state register see the same values.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hazard_state_t;

    // Default number of consecutive MEM_WAIT cycles before giving up.
    localparam int MEM_TIMEOUT_DEFAULT = 64;

    // Wide enough for the largest legal timeout (255).
    localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive data-memory wait cycles and flags when the count has
// reached MEM_TIMEOUT-1, i.e. the last cycle the memory is allowed to respond.
// Ports:
//   clk      in  rising-edge clock
//   clear    in  synchronous clear of the wait counter (has priority)
//   enable   in  count this cycle as a wait cycle
//   expired  out counter equals MEM_TIMEOUT-1
// -----------------------------------------------------------------------------
module mem_wait_timer
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WAIT_CNT_W-1:0] wait_count;

    // The counter stops once it reaches its terminal value; the controller
    // leaves MEM_WAIT at that point, which clears it again.
    always_ff @(posedge clk) begin
        if (clear) begin
            wait_count <= '0;
        end else if (enable && !expired) begin
            wait_count <= wait_count + WAIT_CNT_W'(1);
        end
    end

    assign expired = (wait_count == WAIT_CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard controller for a 5-stage pipeline: load-use stalls, branch/jump
// flushes and data-memory wait freezes with a timeout that ends in a sticky
// error state (left only by reset).
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating stall and flush
// performance counters.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rs_ID, rt_ID          source registers of the instruction in ID
//   MemRead_EX            instruction in EX is a load
//   Write_register_EX     destination register of the instruction in EX
//   BranchTaken, Jump_ID  control transfer resolved in ID
//   mem_req_MEM           instruction in MEM accesses data memory
//   mem_ready             data memory completes the access this cycle
//   PC_write, IFID_write  PC and IF/ID enables
//   IDEX_bubble           zero the ID/EX control fields
//   IF_Flush              turn the IF/ID contents into a NOP
//   pipe_freeze           hold ID/EX, EX/MEM and MEM/WB
//   mem_error             sticky memory-timeout flag
//   stall_cycles          (HAZARD_PERF_CNT_EN) cycles with PC_write=0
//   flush_count           (HAZARD_PERF_CNT_EN) cycles with IF_Flush=1
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic        MemRead_EX,
    input  logic [4:0]  Write_register_EX,
    input  logic        BranchTaken,
    input  logic        Jump_ID,
    input  logic        mem_req_MEM,
    input  logic        mem_ready,
    output logic        PC_write,
    output logic        IFID_write,
    output logic        IDEX_bubble,
    output logic        IF_Flush,
    output logic        pipe_freeze,
    output logic        mem_error
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    hazard_state_t state;
    hazard_state_t state_next;
    logic          mem_wait;
    logic          load_use;
    logic          timer_expired;

    // A memory wait only counts while the controller is still live; once in
    // ERROR the freeze comes from the state itself.
    assign mem_wait = ((state == RUN) || (state == MEM_WAIT)) && mem_req_MEM && !mem_ready;

    // Register 0 is hard-wired to zero, so a load targeting it never creates
    // a real dependency.
    assign load_use = MemRead_EX && (Write_register_EX != 5'd0) &&
                      ((Write_register_EX == rs_ID) || (Write_register_EX == rt_ID));

    // The timer runs only inside MEM_WAIT, so it always starts from zero on
    // the first MEM_WAIT cycle.
    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .clear   (reset || (state != MEM_WAIT)),
        .enable  (mem_wait),
        .expired (timer_expired)
    );

    // Next-state logic. Leaving MEM_WAIT when the wait ends is checked before
    // the timeout so a response on the final allowed cycle still succeeds.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (mem_wait) begin
                    state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (!mem_wait) begin
                    state_next = RUN;
                end else if (timer_expired) begin
                    state_next = ERROR;
                end
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // State register; reset abandons any wait or error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Output decode in priority order: reset, ERROR, freeze, load-use, flush,
    // normal. Holding IF/ID during a stall keeps the branch/jump in ID, so a
    // suppressed flush naturally reappears on the first unstalled cycle.
    always_comb begin
        PC_write    = 1'b1;
        IFID_write  = 1'b1;
        IDEX_bubble = 1'b0;
        IF_Flush    = 1'b0;
        pipe_freeze = 1'b0;
        mem_error   = 1'b0;
        if (reset) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_bubble = 1'b1;
        end else if (state == ERROR) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            pipe_freeze = 1'b1;
            mem_error   = 1'b1;
        end else if (mem_wait) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            pipe_freeze = 1'b1;
        end else if (load_use) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_bubble = 1'b1;
        end else if (BranchTaken || Jump_ID) begin
            IF_Flush    = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating performance counters. Stall cycles are any cycles where the
    // PC is held; reset cycles are excluded because reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 16'd0;
            flush_count  <= 16'd0;
        end else begin
            if (!PC_write && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (IF_Flush && (flush_count != 16'hFFFF)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule
